// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router (header, hold, parity, err).
// Optional ROUTER_REG_ERR_CNT_EN adds a saturating err_count output.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]            err_count,
`endif
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic                  parity_done_d;
    logic                  err_upd;
    logic                  err_new;

    // err is evaluated once, on the first cycle after parity_done rises
    assign err_upd = parity_done & ~parity_done_d & ~detect_add;
    assign err_new = (int_parity != pkt_parity);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_reg <= '0;
        end else if (detect_add && pkt_valid && data_in[1:0] != 2'b11) begin
            header_reg <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout     <= '0;
            hold_reg <= '0;
        end else if (lfd_state) begin
            dout <= header_reg;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_reg <= data_in;
        end else if (laf_state) begin
            dout <= hold_reg;
        end
    end

    // The hold_reg replay in laf_state is deliberately not XORed again
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ header_reg;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_parity <= '0;
        end else if (detect_add) begin
            pkt_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !pkt_valid) begin
            parity_done <= 1'b1;
        end else if (laf_state && low_pkt_valid && !parity_done) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done_d <= 1'b0;
            err           <= 1'b0;
        end else begin
            parity_done_d <= parity_done;
            if (detect_add) begin
                err <= 1'b0;
            end else if (err_upd) begin
                err <= err_new;
            end
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
        end else if (err_upd && err_new && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: randomized packet stimulus with a queue scoreboard for router_reg.
// Expected FIFO bytes and err verdicts come from a packet-level model.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_count    (err_count),
`endif
        .dout         (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] exp_dout[$];
    bit         exp_err[$];
    logic [7:0] last_dout;
    int         cnt_model;
    logic [7:0] pay[0:63];
    bit         fullv[0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a FIFO write happens on lfd, unblocked ld, or laf edges
    bit h1, h2;
    always @(posedge clock) begin
        bit wr;
        bit pd;
        wr = lfd_state | (ld_state & ~fifo_full) | laf_state;
        #1;
        if (!resetn) begin
            h1 = 0;
            h2 = 0;
            last_dout = 8'h00;
        end else begin
            if (wr) begin
                if (exp_dout.size() == 0) begin
                    chk("dout_unexpected_write", 32'd1, 32'd0);
                end else begin
                    last_dout = exp_dout.pop_front();
                    chk("dout_write", dout, last_dout);
                end
            end else begin
                chk("dout_hold", dout, last_dout);
            end
            pd = parity_done;
            if (pd && !h1)
                chk("low_pkt_valid_at_done", low_pkt_valid, 1);
            if (h1 && !h2) begin
                if (exp_err.size() == 0) begin
                    chk("err_unexpected", 32'd1, 32'd0);
                end else begin
                    bit e;
                    e = exp_err.pop_front();
                    chk("err", err, e);
                    chk("low_pkt_valid_cleared", low_pkt_valid, 0);
                    if (e && cnt_model < 255) cnt_model++;
`ifdef ROUTER_REG_ERR_CNT_EN
                    chk("err_count", err_count, cnt_model);
`endif
                end
            end
            h2 = h1;
            h1 = pd;
        end
    end

    task automatic clr();
        detect_add  = 0;
        lfd_state   = 0;
        ld_state    = 0;
        laf_state   = 0;
        full_state  = 0;
        rst_int_reg = 0;
        fifo_full   = 0;
        pkt_valid   = 0;
    endtask

    task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] par, input bit abort);
        int len;
        int nf;
        logic [7:0] x;
        len = int'(hdr[7:2]);
        x = hdr;
        for (int i = 0; i < len; i++) x = x ^ pay[i];
        exp_err.push_back(x != par);
        @(negedge clock); clr();
        detect_add = 1; pkt_valid = 1; data_in = hdr;
        @(negedge clock); clr();
        lfd_state = 1; pkt_valid = 1; data_in = pay[0];
        exp_dout.push_back(hdr);
        for (int i = 0; i <= len; i++) begin
            @(negedge clock); clr();
            ld_state  = 1;
            pkt_valid = (i < len);
            data_in   = (i < len) ? pay[i] : par;
            fifo_full = fullv[i];
            exp_dout.push_back(data_in);
            if (fullv[i]) begin
                nf = $urandom_range(1, 3);
                for (int j = 0; j < nf; j++) begin
                    @(negedge clock); clr();
                    if (j == 0 && i == len) begin
                        chk("pd_low_on_full_parity", parity_done, 0);
                        chk("low_on_full_parity", low_pkt_valid, 1);
                        chk("pkt_parity_latched", dut.pkt_parity, par);
                    end
                    full_state = 1;
                    fifo_full  = (j < nf - 1);
                    pkt_valid  = (i < len);
                end
                @(negedge clock); clr();
                laf_state = 1;
                pkt_valid = (i < len);
            end
        end
        @(negedge clock); clr();
        if (abort) begin
            resetn = 0;
            #1;
            chk("rst_dout", dout, 0);
            chk("rst_parity_done", parity_done, 0);
            chk("rst_low_pkt_valid", low_pkt_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_int_parity", dut.int_parity, 0);
            exp_dout.delete();
            exp_err.delete();
            cnt_model = 0;
            @(negedge clock);
            resetn = 1;
        end else begin
            rst_int_reg = 1;
            data_in = 8'($urandom);
            @(negedge clock); clr();
        end
    endtask

    task automatic set_pkt(input logic [7:0] p0, input logic [7:0] p1);
        for (int i = 0; i < 64; i++) fullv[i] = 0;
        pay[0] = p0;
        pay[1] = p1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr;
        logic [7:0] par;
        int len;
        cnt_model = 0;
        last_dout = 0;
        resetn = 0;
        data_in = 0;
        clr();
        repeat (3) @(negedge clock);
        chk("reset_dout", dout, 0);
        chk("reset_parity_done", parity_done, 0);
        chk("reset_low_pkt_valid", low_pkt_valid, 0);
        chk("reset_err", err, 0);
        resetn = 1;
        @(negedge clock);

        set_pkt(8'h11, 8'h22);
        run_pkt(8'h09, 8'h3A, 0);
        set_pkt(8'h11, 8'h22);
        run_pkt(8'h09, 8'h3B, 0);

        @(negedge clock); clr();
        detect_add = 1; pkt_valid = 1; data_in = 8'h0B;
        @(negedge clock); clr();
        chk("invalid_addr_header", dut.header_reg, 8'h09);
        chk("invalid_addr_err", err, 0);
        chk("invalid_addr_int_parity", dut.int_parity, 0);
        @(negedge clock);

        set_pkt(8'h11, 8'h22);
        fullv[1] = 1;
        run_pkt(8'h09, 8'h3A, 0);
        set_pkt(8'h11, 8'h22);
        fullv[2] = 1;
        run_pkt(8'h09, 8'h3A, 0);

        set_pkt(8'h11, 8'h22);
        run_pkt(8'h09, 8'h3B, 0);
        set_pkt(8'h11, 8'h22);
        run_pkt(8'h09, 8'h3A, 1);
        set_pkt(8'h11, 8'h22);
        run_pkt(8'h09, 8'h3A, 0);

        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 6);
            hdr = {6'(len), 2'($urandom_range(0, 2))};
            par = hdr;
            for (int i = 0; i < 64; i++) begin
                pay[i]   = 8'($urandom);
                fullv[i] = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < len; i++) par = par ^ pay[i];
            if ($urandom_range(0, 2) == 0) par = par ^ 8'($urandom_range(1, 255));
            run_pkt(hdr, par, 0);
        end

        repeat (3) @(negedge clock);
        chk("dout_queue_drained", exp_dout.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router; sits directly downstream of router_fsm and consumes its state strobes.
- Captures the header, routes bytes to the FIFO write-data bus and buffers one byte while the FIFO is full.
- Computes the running XOR parity, latches the packet parity byte and raises low_pkt_valid, parity_done and err.
- parity_done and low_pkt_valid feed back into router_fsm.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout/parity. Header layout: [1:0] address, [DATA_WIDTH-1:2] payload length.

Ports:
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source byte valid; deasserts on the parity byte
- data_in  in  DATA_WIDTH  source byte
- fifo_full  in  1  selected FIFO full
- detect_add  in  1  FSM DECODE_ADDRESS
- lfd_state  in  1  FSM LOAD_FIRST_DATA
- ld_state  in  1  FSM LOAD_DATA
- laf_state  in  1  FSM LOAD_AFTER_FULL
- full_state  in  1  FSM FIFO_FULL_STATE
- rst_int_reg  in  1  FSM CHECK_PARITY_ERROR; clears low_pkt_valid
- parity_done  out  1  parity byte has been accepted
- low_pkt_valid  out  1  pkt_valid fell during LOAD_DATA
- err  out  1  parity mismatch for the last packet
- dout  out  DATA_WIDTH  FIFO write data (write enable comes from FSM write_enb_reg)

Behaviour:
- Reset: resetn=0 clears the following asynchronously: dout, header_reg, hold_reg, int_parity, pkt_parity, parity_done, low_pkt_valid, err, parity_done_d.
- Header capture: detect_add & pkt_valid & data_in[1:0]!=2'b11 -> header_reg<=data_in. Address 2'b11 leaves header_reg unchanged.
- dout, priority top-down:
  - lfd_state -> dout<=header_reg.
  - ld_state & !fifo_full -> dout<=data_in.
  - ld_state & fifo_full -> hold_reg<=data_in; dout holds.
  - laf_state -> dout<=hold_reg.
  - Otherwise dout holds.
- int_parity:
  - detect_add -> 0.
  - lfd_state -> int_parity^header_reg.
  - ld_state & pkt_valid & !full_state -> int_parity^data_in.
  - Otherwise holds. The hold_reg replay in laf_state is never XORed a second time.
- pkt_parity:
  - detect_add -> 0.
  - ld_state & !pkt_valid -> data_in, whether or not fifo_full.
- low_pkt_valid:
  - rst_int_reg -> 0 (highest priority).
  - ld_state & !pkt_valid -> 1.
  - Otherwise holds.
- parity_done:
  - detect_add -> 0.
  - ld_state & !fifo_full & !pkt_valid -> 1.
  - laf_state & low_pkt_valid & !parity_done -> 1.
  - Otherwise holds.
- err:
  - parity_done_d is parity_done delayed one clock.
  - On the cycle where parity_done=1 and parity_done_d=0: err<=(int_parity!=pkt_parity). err is therefore valid one clock after parity_done rises.
  - detect_add clears err. Otherwise err holds until the next packet.
- Source protocol: router_fsm asserts busy in LOAD_FIRST_DATA, so the source holds payload byte 0 through the lfd cycle. Each payload byte is therefore presented exactly once in ld_state.
- Simultaneous detect_add with any load strobe cannot occur (one-hot FSM). If it does, detect_add clears take precedence.
- Reset mid-packet: all registers return to reset values immediately. The next packet must start from a fresh detect_add.

Optional Feature:
- Macro: ROUTER_REG_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0].
  - Increments by 1 each time err is set to 1 and saturates at 8'hFF.
  - Cleared only by resetn.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Good packet: header 8'h09 (len 2, addr 01), payload 8'h11, 8'h22, parity 8'h3A, fifo_full=0.
  - dout sequence 09,11,22,3A.
  - parity_done=1 after the parity ld cycle; low_pkt_valid=1 the same edge.
  - err=0 one cycle later.
- Bad parity: same packet with parity 8'h3B -> err=1 one clock after parity_done rises. With ROUTER_REG_ERR_CNT_EN, err_count=1.
- FIFO full mid-payload: fifo_full=1 in the ld cycle of 8'h22.
  - hold_reg=22 and dout holds 11.
  - full_state cycles follow, then laf_state -> dout=22.
  - int_parity=3A (22 counted once) and err=0.
- Full on parity byte: fifo_full=1 when parity 8'h3A arrives with pkt_valid=0.
  - pkt_parity=3A and low_pkt_valid=1; parity_done stays 0.
  - In laf_state parity_done=1 and dout=3A; then err=0.
- Invalid address: detect_add with data_in=8'h0B (addr 11) after header_reg=09 -> header_reg stays 09; int_parity and err clear to 0.
- Async reset mid-packet: drop resetn during ld_state -> dout, parity_done, low_pkt_valid, err and int_parity=0 before the next clock edge. A following good packet passes with err=0.
